vram_arbiter: RTL and testbench



---
 rtl/vram_pkg.sv | 13 +
 rtl/vram_sp.sv | 19 +
 rtl/vram_arbiter.sv | 104 ++++++++++
 tb/tb_vram_arbiter.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/vram_pkg.sv
// vram_pkg: shared framebuffer geometry, slot constants and pixel type for the VRAM arbiter.
package vram_pkg;
  localparam int FB_W = 160;
  localparam int FB_H = 120;
  localparam int FB_DEPTH = FB_W * FB_H;
  localparam int PIX_W = 12;
  localparam int AW = 15;
  localparam logic [1:0] SLOT_READ = 2'd0;
  typedef logic [PIX_W-1:0] pixel_t;
  function automatic logic [AW-1:0] scan_addr(input logic [6:0] r, input logic [7:0] c);
    return {1'b0, r, 7'b0} + {3'b0, r, 5'b0} + {7'b0, c};
  endfunction
endpackage

// File: rtl/vram_sp.sv
// vram_sp: inferred single-port synchronous RAM with one-cycle read latency.
module vram_sp #(
  parameter int DEPTH = 19200,
  parameter int AW = 15,
  parameter int DW = 12
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);
  logic [DW-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
    else if (re) dout <= mem[addr];
  end
endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: phase-slotted VRAM sharing between VGA scanout and two round-robin writers.
// Define VRAM_CLEAR_EN to fill the framebuffer with CLEAR_COLOR after every reset.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int FB_W = vram_pkg::FB_W,
  parameter int FB_H = vram_pkg::FB_H,
  parameter int DATA_W = vram_pkg::PIX_W,
  parameter int ADDR_W = vram_pkg::AW,
  parameter logic [DATA_W-1:0] CLEAR_COLOR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        phase,
  input  logic [8:0]        row_addr,
  input  logic [9:0]        col_addr,
  output logic [DATA_W-1:0] vga_data,
  input  logic              a_req,
  input  logic              b_req,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] a_wdata,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              a_ack,
  output logic              b_ack,
  output logic              clear_busy
);
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(FB_W * FB_H);
  logic [ADDR_W-1:0] sa_q, wa_q, gaddr, clr_addr, ram_addr;
  logic [DATA_W-1:0] pix_q, vga_q, wd_q, gdata, rdata;
  logic sblank_q, rd_vld_q, pix_vld_q, we_q, a_ack_q, b_ack_q, rr_q;
  logic wslot, clr, can, ga, gb, grant, oor;
`ifdef VRAM_CLEAR_EN
  logic busy_q;
  logic [ADDR_W-1:0] cnt_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b1;
      cnt_q <= '0;
    end else if (busy_q && wslot) begin
      cnt_q <= cnt_q + 1'b1;
      if (cnt_q == DEPTH_A - 1'b1) busy_q <= 1'b0;
    end
  end
  assign clr = busy_q;
  assign clr_addr = cnt_q;
`else
  assign clr = 1'b0;
  assign clr_addr = '0;
`endif
  always_comb begin
    wslot = phase != 2'd3;
    can = wslot && !clr;
    ga = can && a_req && (!b_req || !rr_q);
    gb = can && b_req && !ga;
    grant = ga || gb || (wslot && clr);
    gaddr = clr ? clr_addr : ga ? a_addr : b_addr;
    gdata = clr ? CLEAR_COLOR : ga ? a_wdata : b_wdata;
    oor = gaddr >= DEPTH_A;
  end
  // rr_q set means B has priority on the next simultaneous request
  always_ff @(posedge clk) begin
    if (rst) begin
      vga_q <= '0;
      a_ack_q <= 1'b0;
      b_ack_q <= 1'b0;
      rr_q <= 1'b0;
      we_q <= 1'b0;
      rd_vld_q <= 1'b0;
      pix_vld_q <= 1'b0;
      sblank_q <= 1'b1;
    end else begin
      a_ack_q <= ga;
      b_ack_q <= gb;
      we_q <= grant && !oor;
      wa_q <= gaddr;
      wd_q <= gdata;
      if (ga || gb) rr_q <= ga;
      if (phase == 2'd3) begin
        sa_q <= scan_addr(row_addr[8:2], col_addr[9:2]);
        sblank_q <= row_addr >= 9'd480 || col_addr >= 10'd640;
        vga_q <= pix_vld_q ? pix_q : '0;
      end
      if (phase == SLOT_READ) rd_vld_q <= !sblank_q;
      if (phase == 2'd1) begin
        pix_q <= rdata;
        pix_vld_q <= rd_vld_q;
      end
    end
  end
  assign ram_addr = phase == SLOT_READ ? sa_q : wa_q;
  vram_sp #(.DEPTH(FB_W * FB_H), .AW(ADDR_W), .DW(DATA_W)) u_ram (
    .clk (clk),
    .we  (we_q && phase != SLOT_READ),
    .re  (phase == SLOT_READ && !sblank_q),
    .addr(ram_addr),
    .din (wd_q),
    .dout(rdata)
  );
  assign vga_data = vga_q;
  assign a_ack = a_ack_q;
  assign b_ack = b_ack_q;
  assign clear_busy = clr;
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: scoreboard bench for vram_arbiter; covers the clear engine when VRAM_CLEAR_EN is defined.
module tb_vram_arbiter;
`ifdef VRAM_CLEAR_EN
  localparam logic [11:0] CLR = 12'hE12;
`else
  localparam logic [11:0] CLR = 12'h000;
`endif
  logic clk = 0, rst = 1;
  logic [1:0] phase;
  logic [8:0] row_addr;
  logic [9:0] col_addr;
  logic [11:0] vga_data, a_wdata, b_wdata;
  logic [14:0] a_addr, b_addr;
  logic a_req, b_req, a_ack, b_ack, clear_busy;
  int cyc = 0, nvec = 0, nerr = 0;
  typedef struct {int c; logic [11:0] v;} vexp_t;
  vexp_t vq[$];
  byte aq[$];
  logic [11:0] model [int];
  logic [11:0] prev;
  bit prev_ok = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign phase = cyc[1:0];

  vram_arbiter #(.CLEAR_COLOR(CLR)) dut (
    .clk(clk), .rst(rst), .phase(phase), .row_addr(row_addr), .col_addr(col_addr),
    .vga_data(vga_data), .a_req(a_req), .b_req(b_req), .a_addr(a_addr), .b_addr(b_addr),
    .a_wdata(a_wdata), .b_wdata(b_wdata), .a_ack(a_ack), .b_ack(b_ack), .clear_busy(clear_busy)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  function automatic logic [11:0] mrd(input int a);
    return model.exists(a) ? model[a] : CLR;
  endfunction

  function automatic logic [11:0] pat(input logic [14:0] a);
    return a[11:0] ^ 12'hA5A;
  endfunction

  initial forever begin
    @(posedge clk); #2;
    while (vq.size() > 0 && vq[0].c <= cyc) begin
      vexp_t e;
      e = vq.pop_front();
      chk($sformatf("vga@%0d", e.c), {20'b0, vga_data}, {20'b0, e.v});
    end
  end

  initial forever begin
    @(posedge clk); #2;
    if (a_ack || b_ack) begin
      byte w, g;
      w = aq.size() > 0 ? aq.pop_front() : "-";
      g = (phase == 2'd0) ? "?" : (a_ack && !b_ack) ? "A" : (b_ack && !a_ack) ? "B" : "?";
      chk("ack", {24'b0, g}, {24'b0, w});
    end
  end

  task automatic p0();
    do begin @(posedge clk); #1; end while (phase != 2'd0);
  endtask

  task automatic scan_rc(input int r, input int c, input logic [11:0] exp);
    p0();
    row_addr = 9'(r);
    col_addr = 10'(c);
    if (prev_ok) vq.push_back('{cyc + 7, prev});
    vq.push_back('{cyc + 8, exp});
    vq.push_back('{cyc + 11, exp});
    prev = exp;
    prev_ok = 1;
    repeat (8) @(posedge clk);
  endtask

  task automatic scan_w(input int a);
    scan_rc((a / 160) * 4, (a % 160) * 4, mrd(a));
  endtask

  task automatic burst(input string seq, input bit ua, input bit ub, input int na, input int nb, input int n);
    for (int i = 0; i < seq.len(); i++) aq.push_back(seq[i]);
    p0();
    a_req = ua; b_req = ub;
    a_addr = 15'(na); b_addr = 15'(nb);
    a_wdata = pat(a_addr); b_wdata = pat(b_addr);
    repeat (n) begin
      @(posedge clk); #1;
      if (a_ack) begin model[int'(a_addr)] = a_wdata; a_addr++; a_wdata = pat(a_addr); end
      if (b_ack) begin model[int'(b_addr)] = b_wdata; b_addr++; b_wdata = pat(b_addr); end
    end
    a_req = 0; b_req = 0;
  endtask

  task automatic single(input bit isb, input int ad, input logic [11:0] d);
    int k;
    aq.push_back(isb ? "B" : "A");
    p0();
    if (isb) begin b_req = 1; b_addr = 15'(ad); b_wdata = d; end
    else begin a_req = 1; a_addr = 15'(ad); a_wdata = d; end
    k = 0;
    do begin @(posedge clk); #1; k++; end while (!(a_ack || b_ack) && k < 8);
    chk("single ack seen", {31'b0, a_ack || b_ack}, 1);
    if ((a_ack || b_ack) && ad < 19200) model[ad] = d;
    a_req = 0; b_req = 0;
  endtask

  task automatic wait_clear();
    int k;
    k = 0;
    while (clear_busy && k < 30000) begin @(posedge clk); #1; k++; end
    chk("clear finished", {31'b0, clear_busy}, 0);
  endtask

  initial begin
    a_req = 0; b_req = 0; a_addr = 0; b_addr = 0; a_wdata = 0; b_wdata = 0;
    row_addr = 0; col_addr = 0;
    repeat (6) @(posedge clk);
    p0();
    rst = 0;
    vq.push_back('{cyc, 12'h000});
`ifdef VRAM_CLEAR_EN
    begin
      int nb, f, k;
      nb = 0; f = -1; k = -1;
      aq.push_back("A");
      a_req = 1; a_addr = 15'd5; a_wdata = 12'h0A5;
      for (int i = 0; i < 30000 && k < 0; i++) begin
        if (clear_busy && phase != 2'd3) nb++;
        if (!clear_busy && f < 0) f = cyc;
        if (a_ack) begin k = cyc; a_req = 0; model[5] = 12'h0A5; end
        if (k < 0) begin @(posedge clk); #1; end
      end
      chk("clear write slots", nb, 19200);
      chk("first ack after clear", k - f, 2);
    end
    scan_w(100);
    scan_w(5);
`endif
    single(0, 0, 12'h0AE);
    single(0, 162, 12'h5C3);
    single(0, 19199, 12'h777);
    for (int c = 0; c < 4; c++) scan_rc(0, c, 12'h0AE);
    scan_rc(480, 0, 12'h000);
    scan_rc(0, 640, 12'h000);
    scan_rc(4, 8, 12'h5C3);
    scan_w(19199);
    burst("AAAAAAAAAAAA", 1, 0, 300, 0, 16);
    for (int i = 0; i < 12; i++) scan_w(300 + i);
    p0();
    a_req = 1; a_addr = 0; a_wdata = 12'h123; rst = 1;
    @(posedge clk); #1;
    rst = 0; a_req = 0; prev_ok = 0;
    vq.push_back('{cyc, 12'h000});
`ifdef VRAM_CLEAR_EN
    model.delete();
    wait_clear();
`endif
    scan_w(0);
    fork
      burst("ABABABABABAB", 1, 1, 1000, 2000, 16);
      scan_w(162);
    join
    for (int i = 0; i < 6; i++) begin scan_w(1000 + i); scan_w(2000 + i); end
    single(1, 19200, 12'hBAD);
    scan_w(0);
    scan_w(19199);
    repeat (16) @(posedge clk);
    chk("ack queue drained", aq.size(), 0);
    chk("vga queue drained", vq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
